// File: rtl/ni_tx_pkg.sv
// ni_tx_pkg: flit layout, field positions and shared types for the NI transmitter.
// The header field positions match the router's route-computation decoder.
package ni_tx_pkg;

    // Mesh geometry: 4x4 nodes. A node address is {ypos, xpos}.
    localparam int XPOS_W  = 2;
    localparam int YPOS_W  = 2;
    localparam int UADDR_W = XPOS_W + YPOS_W;
    localparam int MADDR_W = 1 << UADDR_W;   // one bitmap bit per node

    localparam int NUM_VC  = 2;
    localparam int VCH_W   = 1;
    localparam int DATA_W  = 32;

    // Flit field positions. FTYPE and VCH sit at the same place in every flit type.
    localparam int FTYPE_MSB   = 31;
    localparam int FTYPE_LSB   = 30;
    localparam int UM_TYPE_POS = 29;
    localparam int VCH_MSB     = 28;
    localparam int VCH_LSB     = 28;
    localparam int DST_MSB     = 27;
    localparam int DST_LSB     = 24;
    localparam int MDST_MSB    = 23;
    localparam int MDST_LSB    = 8;
    localparam int SRC_MSB     = 7;
    localparam int SRC_LSB     = 4;
    localparam int LEN_MSB     = 3;
    localparam int LEN_LSB     = 0;
    localparam int LEN_FIELD_W = LEN_MSB - LEN_LSB + 1;

    // Body and tail flits carry payload below the VCH field.
    localparam int PL_MSB = 27;
    localparam int PL_LSB = 0;
    localparam int PL_W   = PL_MSB - PL_LSB + 1;

    typedef enum logic [1:0] {
        FT_HEAD     = 2'b00,
        FT_BODY     = 2'b01,
        FT_TAIL     = 2'b10,
        FT_HEADTAIL = 2'b11
    } ftype_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY
    } state_e;

    // Routing information captured from an accepted request.
    typedef struct packed {
        logic                um;
        logic [UADDR_W-1:0]  dst;
        logic [MADDR_W-1:0]  mdst;
        logic [VCH_W-1:0]    vch;
    } route_t;

    // Header flit: only the destination field matching the request type is populated.
    function automatic logic [DATA_W-1:0] make_header(
        input ftype_e                  ft,
        input route_t                  r,
        input logic [UADDR_W-1:0]      src,
        input logic [LEN_FIELD_W-1:0]  len
    );
        logic [DATA_W-1:0] f;
        f                      = '0;
        f[FTYPE_MSB:FTYPE_LSB] = ft;
        f[UM_TYPE_POS]         = r.um;
        f[VCH_MSB:VCH_LSB]     = r.vch;
        f[DST_MSB:DST_LSB]     = r.um ? '0 : r.dst;
        f[MDST_MSB:MDST_LSB]   = r.um ? r.mdst : '0;
        f[SRC_MSB:SRC_LSB]     = src;
        f[LEN_MSB:LEN_LSB]     = len;
        return f;
    endfunction

    // Body or tail flit.
    function automatic logic [DATA_W-1:0] make_body(
        input ftype_e            ft,
        input logic [VCH_W-1:0]  vch,
        input logic [PL_W-1:0]   payload
    );
        logic [DATA_W-1:0] f;
        f                      = '0;
        f[FTYPE_MSB:FTYPE_LSB] = ft;
        f[VCH_MSB:VCH_LSB]     = vch;
        f[PL_MSB:PL_LSB]       = payload;
        return f;
    endfunction

endpackage

// File: rtl/ni_tx_credit_cnt.sv
// ni_tx_credit_cnt: per-VC credit counter. Starts full at BUF_DEPTH, counts down
// on each flit sent and up on each credit returned, saturating at both ends.
module ni_tx_credit_cnt #(
    parameter int BUF_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_,
    input  logic inc_i,          // credit returned by the router
    input  logic dec_i,          // flit sent on this VC
    output logic nonzero_o,      // at least one credit available now
    output logic nonzero_next_o  // at least one credit available next cycle
);

    localparam int            CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a simultaneous send and return cancel out.
    always_comb begin
        // NOTE: default assigned first so every path drives count_d; no latch is inferred.
        count_d = count_q;
        if (inc_i && !dec_i) begin
            if (count_q != FULL) count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) count_d = count_q - CNT_W'(1);
        end
    end

    // Counter register; reset refills the router-side buffer allowance.
    always_ff @(posedge clk or negedge rst_) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_) count_q <= FULL;
        else       count_q <= count_d;
    end

    assign nonzero_o      = (count_q != '0);
    assign nonzero_next_o = (count_d != '0);

    // A return to a full counter means the router and this block disagree on buffer space.
    credit_overflow_a: assert property (@(posedge clk) disable iff (!rst_)
        !(inc_i && !dec_i && (count_q == FULL)))
        else $warning("credit_cnt: credit returned while already at BUF_DEPTH");

    // The transmitter must never send without a credit.
    credit_underflow_a: assert property (@(posedge clk) disable iff (!rst_)
        !(dec_i && !inc_i && (count_q == '0)))
        else $error("credit_cnt: flit sent with no credit");

endmodule

// File: rtl/ni_tx.sv
// ni_tx: network-interface transmitter. Turns PE packet requests into header,
// body and tail flits for the router's local port under credit flow control.
module ni_tx
    import ni_tx_pkg::*;
#(
    parameter int MY_XPOS   = 0,
    parameter int MY_YPOS   = 0,
    parameter int BUF_DEPTH = 4,
    parameter int LENW      = 3   // must not exceed the LEN field width
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_um,
    input  logic [UADDR_W-1:0] req_dst,
    input  logic [MADDR_W-1:0] req_mdst,
    input  logic [VCH_W-1:0]   req_vch,
    input  logic [LENW-1:0]    req_len,
    input  logic               pl_valid,
    output logic               pl_ready,
    input  logic [PL_W-1:0]    pl_data,
    output logic [DATA_W-1:0]  odata,
    output logic               osend,
    input  logic               icredit,
    input  logic [VCH_W-1:0]   icredit_vch,
    output logic               busy,
    output logic               err
);

    localparam logic [UADDR_W-1:0] MY_ADDR = {YPOS_W'(MY_YPOS), XPOS_W'(MY_XPOS)};

    state_e                  state_q, state_d;
    route_t                  route_q, route_d;
    logic [LENW-1:0]         len_q, len_d;
    logic [LENW-1:0]         rem_q, rem_d;     // body/tail flits still to send
    logic [DATA_W-1:0]       odata_q, odata_d;
    logic                    osend_q, osend_d;
    logic                    req_ready_q, req_ready_d;
    logic                    pl_ready_q, pl_ready_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic [LEN_FIELD_W-1:0]  len_field;
    logic                    req_illegal;
    logic                    vc_credit_ok;
    logic [NUM_VC-1:0]       credit_inc;
    logic [NUM_VC-1:0]       credit_dec;
    logic [NUM_VC-1:0]       credit_nz;
    logic [NUM_VC-1:0]       credit_nz_next;

    // A zero-length packet, or a unicast to ourselves, is consumed and flagged.
    assign req_illegal  = (req_len == '0) || (!req_um && (req_dst == MY_ADDR));
    assign vc_credit_ok = credit_nz[route_q.vch];

    // Next-state, request capture and flit formation.
    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        len_d     = len_q;
        rem_d     = rem_q;
        odata_d   = odata_q;
        osend_d   = 1'b0;
        err_d     = 1'b0;
        len_field = '0;
        len_field[LENW-1:0] = len_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (req_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        route_d = '{um: req_um, dst: req_dst, mdst: req_mdst, vch: req_vch};
                        len_d   = req_len;
                        state_d = S_HEAD;
                    end
                end
            end
            S_HEAD: begin
                if (vc_credit_ok) begin
                    osend_d = 1'b1;
                    if (len_q == LENW'(1)) begin
                        odata_d = make_header(FT_HEADTAIL, route_q, MY_ADDR, len_field);
                        state_d = S_IDLE;
                    end else begin
                        odata_d = make_header(FT_HEAD, route_q, MY_ADDR, len_field);
                        rem_d   = len_q - LENW'(1);
                        state_d = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (pl_valid && vc_credit_ok) begin
                    osend_d = 1'b1;
                    rem_d   = rem_q - LENW'(1);
                    if (rem_q == LENW'(1)) begin
                        odata_d = make_body(FT_TAIL, route_q.vch, pl_data);
                        state_d = S_IDLE;
                    end else begin
                        odata_d = make_body(FT_BODY, route_q.vch, pl_data);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Steer the send and the credit return to the counter of their VC.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            credit_dec[v] = osend_d && (route_q.vch == VCH_W'(v));
            credit_inc[v] = icredit && (icredit_vch == VCH_W'(v));
        end
    end

    // Registered handshake/status outputs reflect where the FSM will be next cycle.
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        pl_ready_d  = (state_d == S_BODY) && credit_nz_next[route_q.vch];
    end

    ni_tx_credit_cnt #(.BUF_DEPTH(BUF_DEPTH)) u_credit0 (
        .clk            (clk),
        .rst_           (rst_),
        .inc_i          (credit_inc[0]),
        .dec_i          (credit_dec[0]),
        .nonzero_o      (credit_nz[0]),
        .nonzero_next_o (credit_nz_next[0])
    );

    ni_tx_credit_cnt #(.BUF_DEPTH(BUF_DEPTH)) u_credit1 (
        .clk            (clk),
        .rst_           (rst_),
        .inc_i          (credit_inc[1]),
        .dec_i          (credit_dec[1]),
        .nonzero_o      (credit_nz[1]),
        .nonzero_next_o (credit_nz_next[1])
    );

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= S_IDLE;
            route_q     <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            odata_q     <= '0;
            osend_q     <= 1'b0;
            req_ready_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            odata_q     <= odata_d;
            osend_q     <= osend_d;
            req_ready_q <= req_ready_d;
            pl_ready_q  <= pl_ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign odata     = odata_q;
    assign osend     = osend_q;
    assign req_ready = req_ready_q;
    assign pl_ready  = pl_ready_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ni_tx.sv
// tb_ni_tx: scoreboard bench for ni_tx at node (0,0), BUF_DEPTH 4, LENW 3.
`timescale 1ns/1ps
module tb_ni_tx;

    localparam logic [1:0] T_HEAD     = 2'b00;
    localparam logic [1:0] T_BODY     = 2'b01;
    localparam logic [1:0] T_TAIL     = 2'b10;
    localparam logic [1:0] T_HEADTAIL = 2'b11;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_um = 1'b0;
    logic [3:0]  req_dst = '0;
    logic [15:0] req_mdst = '0;
    logic [0:0]  req_vch = '0;
    logic [2:0]  req_len = '0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [27:0] pl_data = '0;
    logic [31:0] odata;
    logic        osend;
    logic        icredit = 1'b0;
    logic [0:0]  icredit_vch = '0;
    logic        busy;
    logic        err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    int          send_cyc[$];

    ni_tx #(.MY_XPOS(0), .MY_YPOS(0), .BUF_DEPTH(4), .LENW(3)) dut (
        .clk(clk), .rst_(rst_),
        .req_valid(req_valid), .req_ready(req_ready), .req_um(req_um),
        .req_dst(req_dst), .req_mdst(req_mdst), .req_vch(req_vch), .req_len(req_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .odata(odata), .osend(osend),
        .icredit(icredit), .icredit_vch(icredit_vch),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Header as the router decodes it; SRC of node (0,0) is 0.
    function automatic logic [31:0] exp_head(input logic [1:0] ft, input logic um, input logic vch,
                                             input logic [3:0] dst, input logic [15:0] mdst,
                                             input logic [3:0] len);
        return {ft, um, vch, (um ? 4'h0 : dst), (um ? mdst : 16'h0), 4'h0, len};
    endfunction

    function automatic logic [31:0] exp_body(input logic [1:0] ft, input logic vch, input logic [27:0] d);
        return {ft, 1'b0, vch, d};
    endfunction

    // Advance one clock, sample on the falling edge and score any flit sent.
    task automatic cycle();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        if (osend === 1'b1) begin
            send_cyc.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL flit_unexpected: got odata=%h, none expected", odata);
            end else begin
                e = exp_q.pop_front();
                if (odata !== e) begin
                    n_fail++;
                    $display("FAIL flit_data: got odata=%h, expected %h", odata, e);
                end
            end
        end
    endtask

    task automatic issue_req(input logic um, input logic [3:0] dst, input logic [15:0] mdst,
                             input logic vch, input logic [2:0] len);
        int w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            cycle();
            w++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, w);
        end
        req_valid = 1'b1;
        req_um    = um;
        req_dst   = dst;
        req_mdst  = mdst;
        req_vch   = vch;
        req_len   = len;
        cycle();
        req_valid = 1'b0;
    endtask

    // Stream cnt payload words; body index first..first+cnt-1 of total, last is the tail.
    task automatic drive_bodies(input logic vch, input int first, input int cnt, input int total,
                                input int budget);
        int done = 0;
        int waited = 0;
        pl_valid = 1'b1;
        pl_data  = 28'($urandom);
        while (done < cnt && waited < budget) begin
            if (pl_ready === 1'b1) begin
                exp_q.push_back(exp_body((first + done == total) ? T_TAIL : T_BODY, vch, pl_data));
                done++;
                cycle();
                pl_data = 28'($urandom);
            end else begin
                cycle();
            end
            waited++;
        end
        pl_valid = 1'b0;
        cycle();
        n_checks++;
        if (done != cnt) begin
            n_fail++;
            $display("FAIL body_timeout: consumed %0d words, expected %0d", done, cnt);
        end
    endtask

    task automatic return_credit(input logic vch, input int n);
        icredit     = 1'b1;
        icredit_vch = vch;
        for (int i = 0; i < n; i++) cycle();
        icredit = 1'b0;
    endtask

    task automatic test_reset();
        cycle();
        cycle();
        n_checks++;
        if ({odata, osend, req_ready, pl_ready, busy, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: odata=%h osend=%b req_ready=%b pl_ready=%b busy=%b err=%b, expected all 0",
                     odata, osend, req_ready, pl_ready, busy, err);
        end
        n_checks++;
        if (dut.u_credit0.count_q !== 3'd4 || dut.u_credit1.count_q !== 3'd4) begin
            n_fail++;
            $display("FAIL reset_credits: got %0d/%0d, expected 4/4", dut.u_credit0.count_q, dut.u_credit1.count_q);
        end
        rst_ = 1'b1;
        cycle();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b, expected 1", req_ready);
        end
    endtask

    task automatic test_unicast_headtail();
        send_cyc.delete();
        exp_q.push_back(exp_head(T_HEADTAIL, 1'b0, 1'b0, 4'h6, 16'h0, 4'd1));
        issue_req(1'b0, 4'h6, 16'hFFFF, 1'b0, 3'd1);   // dst (x=2,y=1); mdst must be ignored
        n_checks++;
        if (busy !== 1'b1 || osend !== 1'b0) begin
            n_fail++;
            $display("FAIL ht_busy: busy=%b osend=%b, expected 1/0", busy, osend);
        end
        cycle();
        n_checks++;
        if (osend !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ht_send: osend=%b busy=%b, expected 1/0", osend, busy);
        end
        n_checks++;
        if (dut.u_credit0.count_q !== 3'd3 || dut.u_credit1.count_q !== 3'd4) begin
            n_fail++;
            $display("FAIL ht_credits: got %0d/%0d, expected 3/4", dut.u_credit0.count_q, dut.u_credit1.count_q);
        end
        return_credit(1'b0, 1);
        n_checks++;
        if (dut.u_credit0.count_q !== 3'd4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ht_refill: credit0=%0d pending=%0d, expected 4/0", dut.u_credit0.count_q, exp_q.size());
        end
    endtask

    task automatic test_multicast();
        send_cyc.delete();
        exp_q.push_back(exp_head(T_HEAD, 1'b1, 1'b1, 4'h0, 16'h000A, 4'd4));
        issue_req(1'b1, 4'hF, 16'h000A, 1'b1, 3'd4);
        drive_bodies(1'b1, 1, 3, 3, 20);
        n_checks++;
        if (send_cyc.size() != 4 || (send_cyc[send_cyc.size()-1] - send_cyc[0]) != 3) begin
            n_fail++;
            $display("FAIL mc_consecutive: %0d flits, expected 4 on consecutive cycles", send_cyc.size());
        end
        n_checks++;
        if (dut.u_credit1.count_q !== 3'd0 || dut.u_credit0.count_q !== 3'd4) begin
            n_fail++;
            $display("FAIL mc_credits: got %0d/%0d, expected 4/0", dut.u_credit0.count_q, dut.u_credit1.count_q);
        end
        return_credit(1'b1, 4);
        n_checks++;
        if (dut.u_credit1.count_q !== 3'd4 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mc_end: credit1=%0d busy=%b pending=%0d, expected 4/0/0",
                     dut.u_credit1.count_q, busy, exp_q.size());
        end
    endtask

    task automatic test_credit_stall();
        int c0;
        send_cyc.delete();
        exp_q.push_back(exp_head(T_HEAD, 1'b0, 1'b0, 4'h3, 16'h0, 4'd6));
        issue_req(1'b0, 4'h3, 16'h0, 1'b0, 3'd6);
        drive_bodies(1'b0, 1, 3, 5, 20);
        n_checks++;
        if (send_cyc.size() != 4 || dut.u_credit0.count_q !== 3'd0) begin
            n_fail++;
            $display("FAIL stall_first: %0d flits credit0=%0d, expected 4/0", send_cyc.size(), dut.u_credit0.count_q);
        end
        pl_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (osend !== 1'b0 || pl_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: osend=%b pl_ready=%b, expected 0/0", osend, pl_ready);
            end
        end
        return_credit(1'b0, 1);
        c0 = cyc;
        n_checks++;
        if (osend !== 1'b0 || pl_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_refill: osend=%b pl_ready=%b, expected 0/1", osend, pl_ready);
        end
        exp_q.push_back(exp_body(T_BODY, 1'b0, pl_data));
        cycle();
        pl_data = 28'($urandom);
        n_checks++;
        if (send_cyc.size() != 5 || send_cyc[send_cyc.size()-1] != c0 + 1) begin
            n_fail++;
            $display("FAIL stall_one_more: %0d flits, expected 5 with the last on the cycle after the credit",
                     send_cyc.size());
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (osend !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_again: osend=%b, expected 0", osend);
            end
        end
        // Refill one credit, then return another in the same cycle the tail is sent.
        return_credit(1'b0, 1);
        exp_q.push_back(exp_body(T_TAIL, 1'b0, pl_data));
        return_credit(1'b0, 1);
        pl_valid = 1'b0;
        n_checks++;
        if (dut.u_credit0.count_q !== 3'd1 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL send_and_return: credit0=%0d busy=%b pending=%0d, expected 1/0/0",
                     dut.u_credit0.count_q, busy, exp_q.size());
        end
        return_credit(1'b0, 3);
        n_checks++;
        if (dut.u_credit0.count_q !== 3'd4) begin
            n_fail++;
            $display("FAIL credit_refill: credit0=%0d, expected 4", dut.u_credit0.count_q);
        end
        return_credit(1'b0, 1);   // excess return: counter must saturate
        n_checks++;
        if (dut.u_credit0.count_q !== 3'd4) begin
            n_fail++;
            $display("FAIL credit_saturate: credit0=%0d, expected 4", dut.u_credit0.count_q);
        end
    endtask

    task automatic test_illegal();
        issue_req(1'b0, 4'h5, 16'h0, 1'b0, 3'd0);     // zero length
        n_checks++;
        if (err !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0 || osend !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_len: err=%b req_ready=%b busy=%b osend=%b, expected 1/1/0/0",
                     err, req_ready, busy, osend);
        end
        cycle();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_len_pulse: err=%b, expected 0", err);
        end
        issue_req(1'b0, 4'h0, 16'h0, 1'b1, 3'd3);     // unicast to self
        n_checks++;
        if (err !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0 || osend !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_self: err=%b req_ready=%b busy=%b osend=%b, expected 1/1/0/0",
                     err, req_ready, busy, osend);
        end
        cycle();
        cycle();
        n_checks++;
        if (err !== 1'b0 || dut.u_credit1.count_q !== 3'd4) begin
            n_fail++;
            $display("FAIL illegal_self_after: err=%b credit1=%0d, expected 0/4", err, dut.u_credit1.count_q);
        end
    endtask

    task automatic test_reset_mid_body();
        exp_q.push_back(exp_head(T_HEAD, 1'b0, 1'b1, 4'h9, 16'h0, 4'd5));
        issue_req(1'b0, 4'h9, 16'h0, 1'b1, 3'd5);
        drive_bodies(1'b1, 1, 1, 4, 20);
        pl_valid = 1'b1;
        #2 rst_ = 1'b0;
        #1;
        n_checks++;
        if ({odata, osend, req_ready, pl_ready, busy, err} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: odata=%h osend=%b req_ready=%b pl_ready=%b busy=%b err=%b, expected all 0",
                     odata, osend, req_ready, pl_ready, busy, err);
        end
        n_checks++;
        if (dut.u_credit0.count_q !== 3'd4 || dut.u_credit1.count_q !== 3'd4) begin
            n_fail++;
            $display("FAIL midreset_credits: got %0d/%0d, expected 4/4", dut.u_credit0.count_q, dut.u_credit1.count_q);
        end
        pl_valid = 1'b0;
        cycle();
        rst_ = 1'b1;
        exp_q.push_back(exp_head(T_HEAD, 1'b0, 1'b0, 4'hD, 16'h0, 4'd2));
        issue_req(1'b0, 4'hD, 16'h0, 1'b0, 3'd2);
        drive_bodies(1'b0, 1, 1, 1, 20);
        n_checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_next: pending=%0d busy=%b, expected 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        send_cyc.delete();
        exp_q.push_back(exp_head(T_HEADTAIL, 1'b0, 1'b0, 4'h1, 16'h0, 4'd1));
        issue_req(1'b0, 4'h1, 16'h0, 1'b0, 3'd1);
        exp_q.push_back(exp_head(T_HEADTAIL, 1'b1, 1'b1, 4'h0, 16'h8001, 4'd1));
        issue_req(1'b1, 4'h0, 16'h8001, 1'b1, 3'd1);
        cycle();
        cycle();
        n_checks++;
        if (send_cyc.size() != 2 || (send_cyc[1] - send_cyc[0]) != 2) begin
            n_fail++;
            $display("FAIL b2b_gap: %0d flits, expected 2 separated by exactly one idle cycle", send_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_unicast_headtail();
        test_multicast();
        test_credit_stall();
        test_illegal();
        test_reset_mid_body();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d flits never sent, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ni_tx.md
Name: ni_tx

Overview:
- Network-interface transmitter that sits between a PE and its router's local input port.
- Encodes packet requests into flits (header, body, tail) in the header format the router's route computation decodes: UM_TYPE, DST/MDST, VCH.
- Injects flits under credit-based flow control across the 2 virtual channels.

Parameters:
- MY_XPOS, 0, X coordinate of this node; placed in the header SRC field.
- MY_YPOS, 0, Y coordinate of this node; placed in the header SRC field.
- BUF_DEPTH, 4, router input-buffer depth per VC; this is the initial credit count.
- LENW, 3, width of the packet-length field; maximum length is 2^LENW-1 flits.

Ports:
- clk  in  1  clock
- rst_  in  1  asynchronous active-low reset
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted this cycle
- req_um  in  1  request type: 0 = unicast, 1 = multicast
- req_dst  in  [`UADDR:0]  unicast destination
- req_mdst  in  [`MADDR:0]  multicast destination bitmap
- req_vch  in  [`VCHW:0]  VC to inject on
- req_len  in  LENW  total flits including header; legal range 1..2^LENW-1
- pl_valid  in  1  body payload word valid
- pl_ready  out  1  payload word consumed this cycle
- pl_data  in  [`PLW:0]  body payload word
- odata  out  [`DATAW:0]  flit to router
- osend  out  1  odata valid this cycle
- icredit  in  1  credit return strobe
- icredit_vch  in  [`VCHW:0]  VC of the returned credit
- busy  out  1  packet in flight (state not IDLE)
- err  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset, asynchronous on rst_ low:
  - state = IDLE.
  - Both credit counters = BUF_DEPTH.
  - odata = 0; osend, req_ready, pl_ready, busy, err = 0.
- All outputs are registered; a flit appears on odata/osend one cycle after the accepting edge.
- FSM states: IDLE, HEAD, BODY.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch um/dst/mdst/vch/len and go to HEAD.
  - Illegal request (req_len == 0, or unicast with req_dst equal to own address): consume it, pulse err for one cycle, stay in IDLE, send nothing.
- HEAD:
  - When credit[vch] > 0, emit the header flit and decrement that credit.
  - Header contents:
    - FTYPE = HEAD, or HEADTAIL when len == 1.
    - UM_TYPE = um.
    - VCH = vch.
    - DST field = dst when unicast, else 0.
    - MDST field = mdst when multicast, else 0.
    - SRC = {MY_YPOS, MY_XPOS}.
    - LEN = len.
  - len == 1: return to IDLE. Otherwise load remaining = len-1 and go to BODY.
- BODY:
  - A flit is sent only when pl_valid && credit[vch] > 0. In that cycle pl_ready = 1.
  - Flit contents: FTYPE = BODY, or TAIL when remaining == 1; VCH = vch; payload = pl_data.
  - Decrement remaining. After the tail flit, go to IDLE.
- osend pulses exactly once per flit. No flit is sent when the credit count is 0, including the cycle in which that count is refilled from 0.
- Credits:
  - Credit return and send on the same VC in the same cycle: count unchanged.
  - Credit return while the count equals BUF_DEPTH: count saturates at BUF_DEPTH. Simulation assertion fires.
- Only one packet is in flight at a time, so VC interleaving never occurs.
- Back-to-back requests: earliest acceptance is the cycle after the tail (or HEADTAIL) is sent. Minimum gap is one IDLE cycle.
- Reset mid-packet aborts the packet immediately with no tail. Credits are re-initialised; the router is assumed reset together with this block.

Decomposition:
- Shared define.v gains:
  - FTYPE_MSB/LSB and the encodings HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEADTAIL = 2'b11.
  - SRC_MSB/LSB, LEN_MSB/LSB, PLW.
- Existing fields UM_TYPE, DST, MDST and VCH are reused unchanged, so header encoding and route-computation decoding stay consistent.
- One sub-module: credit_cnt, a per-VC saturating up/down counter parameterised by BUF_DEPTH with a nonzero output, instantiated twice.

Test Plan:
- Unicast, vch=0, len=1, dst=(2,1), from node (0,0), credits full -> one HEADTAIL flit: UM_TYPE=0, DST=(2,1), VCH=0, SRC=0. credit[0] goes 4 to 3. busy high for one cycle.
- Multicast, vch=1, len=4, mdst=0b1010, pl_valid held high -> flits HEAD, BODY, BODY, TAIL on consecutive cycles. MDST=0b1010 and DST=0 in header. credit[1] = 0 afterwards. credit[0] untouched.
- len=6 on vch=0, no credit returns -> exactly 4 flits, then osend stays 0 and pl_ready stays 0. One icredit on vch=0 -> exactly one more flit, on the cycle after the credit.
- Simultaneous send and icredit on the same VC -> count unchanged. icredit with count at BUF_DEPTH -> stays 4 and assertion fires.
- req_len=0, or unicast dst equal to own address (0,0) -> err pulses once, no osend, req_ready stays high.
- rst_ asserted mid-BODY, asynchronously between clock edges -> outputs zero immediately, state IDLE, both credits = 4. The next request is sent with a correct header.
